// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the PD pipeline writeback stage.
//   wbsel_e  - writeback source select (ALU, MEM, PC+4, zero)
//   LB..LHU  - RV32I load funct3 encodings
//   memwb_t  - contents of the MEM/WB pipeline register
// The widths in memwb_t follow WB_DWIDTH/WB_AWIDTH/WB_RWIDTH; the stage
// parameters are expected to match them.
package wb_pkg;

  localparam int WB_DWIDTH = 32;
  localparam int WB_AWIDTH = 32;
  localparam int WB_RWIDTH = 5;

  typedef enum logic [1:0] {
    WBSEL_ALU = 2'b00,
    WBSEL_MEM = 2'b01,
    WBSEL_PC4 = 2'b10,
    WBSEL_DEF = 2'b11
  } wbsel_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef struct packed {
    logic                 valid;
    logic [WB_AWIDTH-1:0] pc;
    logic [WB_DWIDTH-1:0] alu_res;
    logic [WB_DWIDTH-1:0] mem_data;
    logic [2:0]           funct3;
    wbsel_e               wbsel;
    logic                 regwren;
    logic [WB_RWIDTH-1:0] rd;
    logic                 brtaken;
  } memwb_t;

endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: combinational load alignment and extension.
// Ports:
//   word       in  32  aligned memory word
//   funct3     in  3   load size/sign (RV32I encoding)
//   offset     in  2   byte offset within the word (address bits [1:0])
//   data       out 32  selected and sign/zero-extended load data
//   misaligned out 1   halfword at odd offset or word at non-zero offset
module wb_load_align
  import wb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = word[{offset, 3'b000} +: 8];
    half_sel   = offset[1] ? word[31:16] : word[15:0];
    data       = word;
    misaligned = 1'b0;
    case (funct3)
      LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LBU: data = {24'h0, byte_sel};
      LH: begin
        data       = {{16{half_sel[15]}}, half_sel};
        misaligned = offset[0];
      end
      LHU: begin
        data       = {16'h0, half_sel};
        misaligned = offset[0];
      end
      LW:  misaligned = (offset != 2'b00);
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: registered writeback stage (MEM/WB register, load
// alignment, writeback mux, register-file write port, next-PC).
// Ports:
//   clk_i, rst_ni            clock (rising) / async active-low reset
//   valid_i, stall_i, flush_i pipeline control
//   pc_i, alu_res_i, memory_data_i, funct3_i, wbsel_i, regwren_i, rd_i,
//   brtaken_i                 MEM-stage instruction fields
//   rf_we_o, rf_waddr_o, rf_wdata_o  register-file write / forwarding bus
//   next_pc_o, next_pc_valid_o       redirect target
//   misalign_o                misaligned load flag
//   retire_o, instret_o       retirement pulse and 64-bit counter
// Build option: define WB_INSTRET_EN to build the retired-instruction
// counter; otherwise instret_o is tied to zero.
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int RWIDTH = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] alu_res_i,
  input  logic [DWIDTH-1:0] memory_data_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        wbsel_i,
  input  logic              regwren_i,
  input  logic [RWIDTH-1:0] rd_i,
  input  logic              brtaken_i,
  output logic              rf_we_o,
  output logic [RWIDTH-1:0] rf_waddr_o,
  output logic [DWIDTH-1:0] rf_wdata_o,
  output logic [AWIDTH-1:0] next_pc_o,
  output logic              next_pc_valid_o,
  output logic              misalign_o,
  output logic              retire_o,
  output logic [63:0]       instret_o
);

  memwb_t            memwb;
  logic [DWIDTH-1:0] load_data;
  logic              load_misaligned;
  logic [AWIDTH-1:0] pc_plus4;

  // Flush beats stall; a flush only kills the valid bit so the data
  // fields are left as they were.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      memwb <= '0;
    end else if (flush_i) begin
      memwb.valid <= 1'b0;
    end else if (!stall_i) begin
      memwb.valid    <= valid_i;
      memwb.pc       <= pc_i;
      memwb.alu_res  <= alu_res_i;
      memwb.mem_data <= memory_data_i;
      memwb.funct3   <= funct3_i;
      memwb.wbsel    <= wbsel_e'(wbsel_i);
      memwb.regwren  <= regwren_i;
      memwb.rd       <= rd_i;
      memwb.brtaken  <= brtaken_i;
    end
  end

  wb_load_align u_load_align (
    .word       (memwb.mem_data),
    .funct3     (memwb.funct3),
    .offset     (memwb.alu_res[1:0]),
    .data       (load_data),
    .misaligned (load_misaligned)
  );

  assign pc_plus4 = memwb.pc + AWIDTH'(4);

  // Writeback source select; PC+4 wraps naturally at the address width.
  always_comb begin
    rf_wdata_o = '0;
    case (memwb.wbsel)
      WBSEL_ALU: rf_wdata_o = memwb.alu_res;
      WBSEL_MEM: rf_wdata_o = load_data;
      WBSEL_PC4: rf_wdata_o = DWIDTH'(pc_plus4);
      default:   rf_wdata_o = '0;
    endcase
  end

  assign misalign_o = memwb.valid & (memwb.wbsel == WBSEL_MEM) & load_misaligned;
  assign rf_we_o    = memwb.valid & memwb.regwren & (memwb.rd != '0) & ~misalign_o;
  assign rf_waddr_o = memwb.rd;

  // Next PC is gated by the valid bit so a bubble (and reset) drives zero
  // rather than the stale PC+4.
  assign next_pc_o = !memwb.valid ? '0 :
                     (memwb.brtaken | (memwb.wbsel == WBSEL_PC4)) ?
                     memwb.alu_res[AWIDTH-1:0] : pc_plus4;
  assign next_pc_valid_o = memwb.valid;

  // The only output with a combinational dependence on stall_i.
  assign retire_o = memwb.valid & ~stall_i;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instret_q <= '0;
    end else if (retire_o) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret_o = instret_q;
`else
  assign instret_o = '0;
`endif

endmodule
